// File: rtl/tt_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// tt_sweep_ctrl_if
//   Groups the host-side and logic-block-side signals of tt_sweep_ctrl.
//
//   master : the environment (test/host controller plus the block under
//            evaluation). It drives start, abort and dut_out and observes
//            the results.
//   slave  : the sweep controller itself.
//
//   start       host -> ctrl   begin a sweep (accepted in IDLE only)
//   abort       host -> ctrl   cancel a sweep; wins over start
//   dut_out     block -> ctrl  output of the block under evaluation
//   drv_in1..4  ctrl -> block  block inputs, row = {in1,in2,in3,in4}
//   busy        ctrl -> host   high while settling/sampling
//   done        ctrl -> host   one-cycle completion pulse
//   pass        ctrl -> host   no mismatch at the last completed sweep
//   mismatch    ctrl -> host   bit r set if row r failed
//   first_fail  ctrl -> host   lowest failing row, 0 when none
// -----------------------------------------------------------------------------
interface tt_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        dut_out;
  logic        drv_in1;
  logic        drv_in2;
  logic        drv_in3;
  logic        drv_in4;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] mismatch;
  logic [3:0]  first_fail;

  modport master (
    output start, abort, dut_out,
    input  drv_in1, drv_in2, drv_in3, drv_in4,
    input  busy, done, pass, mismatch, first_fail
  );

  modport slave (
    input  start, abort, dut_out,
    output drv_in1, drv_in2, drv_in3, drv_in4,
    output busy, done, pass, mismatch, first_fail
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tt_sweep_ctrl
//   Exhaustive truth-table sweeper for a 4-input / 1-output combinational
//   block. Rows 0..15 are driven in order; each row is held SETTLE cycles,
//   then dut_out is sampled and compared with TT[15-row] (row 0 = TT MSB).
//   Reports a per-row mismatch mask, the lowest failing row and a pass flag.
//
// Parameters
//   TT      expected truth table (default 16'h1D95)
//   SETTLE  settle cycles before sampling, >= 1
//   CNT_W   settle/sample counter width, must hold SETTLE and STABLE
//   STABLE  consecutive samples per row (multi-sample build only), >= 1
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    tt_sweep_ctrl_if.slave: start, abort, dut_out in;
//          drv_in1..4, busy, done, pass, mismatch, first_fail out
//
// Build option
//   TT_SWEEP_STABLE_EN : when defined, each row is sampled on STABLE
//   consecutive edges and fails if any sample differs (row hold becomes
//   SETTLE+STABLE cycles). When undefined, one sample per row.
// -----------------------------------------------------------------------------
module tt_sweep_ctrl #(
  parameter logic [15:0] TT     = 16'h1D95,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned STABLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  tt_sweep_ctrl_if.slave bus
);

`ifdef TT_SWEEP_STABLE_EN
  localparam int unsigned SAMPLE_CYC = STABLE;
`else
  // Single sample per row; STABLE has no effect in this build.
  localparam int unsigned SAMPLE_CYC = 1 + 0 * STABLE;
`endif

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [3:0]       r_row;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_drv;
  logic [15:0]      r_mismatch;
  logic [3:0]       r_first_fail;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_active;
  logic             w_abort_act;
  logic             w_settle_last;
  logic             w_sample_last;
  logic             w_row_last;
  logic             w_expected;
  logic             w_miscmp;
  logic [15:0]      w_fail_bit;
  logic [15:0]      w_mismatch_nx;
  logic             w_busy;
  logic             w_done;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign w_start_ok    = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_active      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign w_abort_act   = w_active && bus.abort;
  assign w_settle_last = (r_cnt == SETTLE_LAST);
  assign w_sample_last = (r_cnt == SAMPLE_LAST);
  assign w_row_last    = (r_row == 4'hF);

  assign w_expected    = TT[4'd15 - r_row];
  assign w_miscmp      = (bus.dut_out != w_expected);
  assign w_fail_bit    = 16'(w_miscmp) << r_row;
  // Mask including the current sample, so pass at DONE entry sees row 15.
  assign w_mismatch_nx = r_mismatch | w_fail_bit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (w_settle_last) begin
          w_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (w_sample_last) begin
          w_next = w_row_last ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      ST_SETTLE: w_busy = 1'b1;
      ST_SAMPLE: w_busy = 1'b1;
      ST_DONE:   w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: row/counter, driven inputs and result registers
  // ---------------------------------------------------------------------------
  // The counter is reused: it counts settle cycles in SETTLE and sample
  // edges in SAMPLE, restarting from 0 on each phase change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_cnt        <= '0;
      r_drv        <= '0;
      r_mismatch   <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_abort_act) begin
      // Partial mismatch/first_fail are kept for inspection.
      r_row  <= '0;
      r_cnt  <= '0;
      r_drv  <= '0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_row        <= '0;
            r_cnt        <= '0;
            r_drv        <= '0;
            r_mismatch   <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_settle_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          r_mismatch <= w_mismatch_nx;
          // Rows ascend, so the first miscompare is also the lowest row.
          if (w_miscmp && (r_mismatch == '0)) begin
            r_first_fail <= r_row;
          end
          if (w_sample_last) begin
            r_cnt <= '0;
            if (w_row_last) begin
              r_row  <= '0;
              r_drv  <= '0;
              r_pass <= (w_mismatch_nx == '0);
            end else begin
              r_row <= r_row + 4'd1;
              r_drv <= r_row + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.drv_in1    = r_drv[3];
  assign bus.drv_in2    = r_drv[2];
  assign bus.drv_in3    = r_drv[1];
  assign bus.drv_in4    = r_drv[0];
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.pass       = r_pass;
  assign bus.mismatch   = r_mismatch;
  assign bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//   Self-checking bench for tt_sweep_ctrl. The block under evaluation is
//   modelled as an arbitrary 16-entry truth table (func) optionally inverted
//   for a single cycle (glitch). Expected results come from comparing func
//   with the reference table row by row and from the sweep timing rules.
// -----------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

  localparam logic [15:0] TT_REF = 16'h1D95;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned STABLE = 4;
`ifdef TT_SWEEP_STABLE_EN
  localparam int unsigned SAMPLES = STABLE;
`else
  localparam int unsigned SAMPLES = 1;
`endif
  localparam int unsigned HOLD  = SETTLE + SAMPLES;
  localparam int unsigned SWEEP = 16 * HOLD;

  logic        clk;
  logic        rst_n;
  logic [15:0] r_func;
  logic        r_glitch;
  logic [3:0]  w_row;

  int unsigned n_chk;
  int unsigned n_fail;

  tt_sweep_ctrl_if bus ();

  tt_sweep_ctrl #(
    .TT     (TT_REF),
    .SETTLE (SETTLE),
    .CNT_W  (8),
    .STABLE (STABLE)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign w_row       = {bus.drv_in1, bus.drv_in2, bus.drv_in3, bus.drv_in4};
  assign bus.dut_out = r_func[4'd15 - w_row] ^ r_glitch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Row r fails when the block's value differs from the reference value.
  function automatic logic [15:0] model_mask(input logic [15:0] func);
    logic [15:0] tt_v;
    logic [15:0] m;
    tt_v = TT_REF;
    m    = '0;
    for (int r = 0; r < 16; r++) begin
      if (tt_v[15-r] != func[15-r]) m[r] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] ff;
    ff = '0;
    for (int r = 15; r >= 0; r--) begin
      if (m[r]) ff = 4'(r);
    end
    return ff;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'h0);
    chk({tag, "_first_fail"}, 32'(bus.first_fail), 32'h0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_drv"}, 32'(w_row), 32'h0);
  endtask

  // Full sweep. glitch_n >= 0 inverts dut_out during the cycle after the
  // glitch_n-th edge following the start edge; extra adds expected fails.
  task automatic run_sweep(input string tag, input logic [15:0] func,
                           input bit hold_start, input int glitch_n,
                           input logic [15:0] extra);
    int unsigned n;
    int unsigned drv_err;
    bit          seen_done;
    logic [15:0] exp_m;
    r_func = func;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    r_glitch = (glitch_n == 0);
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'h1);
    n         = 0;
    drv_err   = 0;
    seen_done = 1'b0;
    while (!seen_done && n < SWEEP + 16) begin
      @(negedge clk);
      n++;
      r_glitch = (glitch_n >= 0) && (n == int'(glitch_n));
      if (bus.done) seen_done = 1'b1;
      else if (n < SWEEP && 32'(w_row) != n / HOLD) drv_err++;
    end
    bus.start = 1'b0;
    r_glitch  = 1'b0;
    exp_m = model_mask(func) | extra;
    chk({tag, "_done_seen"}, 32'(seen_done), 32'h1);
    chk({tag, "_done_latency"}, n, SWEEP);
    chk({tag, "_drv_seq_errs"}, drv_err, 32'h0);
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'h0);
    chk({tag, "_drv_in_done"}, 32'(w_row), 32'h0);
    chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'(exp_m));
    chk({tag, "_first_fail"}, 32'(bus.first_fail), 32'(lowest_set(exp_m)));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(exp_m == '0));
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(bus.done), 32'h0);
    chk({tag, "_pass_hold"}, 32'(bus.pass), 32'(exp_m == '0));
  endtask

  // Abort one cycle after row k (k >= 1) is driven, i.e. inside its settle.
  task automatic run_abort(input string tag, input logic [15:0] func, input int unsigned k);
    int unsigned guard;
    int unsigned dones;
    logic [15:0] part;
    r_func = func;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (32'(w_row) != k && guard < SWEEP) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_row_reached"}, 32'(w_row), k);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    part = model_mask(func) & 16'((32'h1 << k) - 1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_drv"}, 32'(w_row), 32'h0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'h0);
    chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'(part));
    chk({tag, "_first_fail"}, 32'(bus.first_fail), 32'(lowest_set(part)));
    dones = 0;
    for (int i = 0; i < int'(2 * HOLD); i++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    chk({tag, "_no_done_after"}, dones, 32'h0);
  endtask

  initial begin
    int unsigned row;
    int unsigned wait_n;
    logic [15:0] func;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    r_func    = TT_REF;
    r_glitch  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sweeps: correct block, stuck-at-0, stuck-at-1.
    run_sweep("good", TT_REF, 1'b0, -1, 16'h0);
    run_sweep("stuck0", 16'h0000, 1'b0, -1, 16'h0);
    chk("stuck0_mask_const", 32'(bus.mismatch), 32'hA9B8);
    chk("stuck0_ff_const", 32'(bus.first_fail), 32'h3);
    run_sweep("stuck1", 16'hFFFF, 1'b1, -1, 16'h0);
    chk("stuck1_mask_const", 32'(bus.mismatch), 32'h5647);
    chk("stuck1_ff_const", 32'(bus.first_fail), 32'h0);

    // start and abort together in IDLE: stays idle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_busy", 32'(bus.busy), 32'h0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy_later", 32'(bus.busy), 32'h0);
    chk("start_abort_pass_kept", 32'(bus.pass), 32'h0);

    // Abort at row 6, then a clean sweep from row 0.
    run_abort("abort6", 16'h0000, 6);
    run_sweep("after_abort", TT_REF, 1'b0, -1, 16'h0);

    // Reset mid-sweep.
    r_func = 16'h0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    wait_n = $urandom_range(HOLD * 4, HOLD * 12);
    repeat (wait_n) @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs_zero("midreset");
    @(negedge clk);
    chk("midreset_idle", 32'(bus.busy), 32'h0);

    // Glitch inside the sample window of row 9 and of random rows.
    run_sweep("glitch9", TT_REF, 1'b0, int'(9 * HOLD + SETTLE + (SAMPLES - 1) / 2), 16'h0200);
    for (int i = 0; i < 2; i++) begin
      row = $urandom_range(0, 15);
      run_sweep("glitch_rnd", TT_REF, 1'b0,
                int'(row * HOLD + SETTLE + $urandom_range(0, SAMPLES - 1)),
                16'(32'h1 << row));
    end
    // Glitch during settle is not sampled.
    row = $urandom_range(1, 15);
    run_sweep("glitch_settle", TT_REF, 1'b0, int'(row * HOLD), 16'h0);

    // Randomized blocks.
    for (int i = 0; i < 6; i++) begin
      func = 16'($urandom());
      if ($urandom_range(0, 3) == 0) func = TT_REF;
      run_sweep("rand", func, 1'($urandom_range(0, 1)), -1, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      run_abort("abort_rnd", 16'($urandom()), $urandom_range(1, 15));
    end
    run_sweep("final", 16'($urandom()), 1'b0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
